// File: rtl/i2c_mem_slave_param.sv
// -----------------------------------------------------------------------------
// i2c_mem_slave_param
//
// Parametrised I2C memory slave. The first byte after START is the device
// address plus R/W. Writes carry a register-pointer byte and then data bytes.
// Reads return bytes starting at the current pointer. The pointer
// auto-increments and wraps at MEM_DEPTH. A repeated START keeps the pointer,
// so the usual "write pointer, restart, read" sequence works.
// SCL/SDA are oversampled on clk, which must run at least 8x the SCL rate.
//
// Parameters:
//   SLAVE_ADDR  7-bit device address
//   MEM_DEPTH   number of 8-bit words (2..256)
//   PTR_W       pointer register width
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   wp        write protect (only when I2C_MEM_WP_EN is defined)
//   scl       bus SCL level
//   sda_in    bus SDA level
//   sda_oe    1 = pull SDA low (open drain, never driven high)
//   busy      high from address match until STOP / NACK / mismatch
//   wr_pulse  one-clk strobe per data byte committed to memory
//   ptr       current memory pointer
//
// Optional feature macro: I2C_MEM_WP_EN
//   Defined:   adds input wp. While wp=1, data bytes are NACKed and are not
//              written, and the pointer still advances.
//   Undefined: no wp port, and all writes are accepted.
// -----------------------------------------------------------------------------
module i2c_mem_slave_param #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1F,
  parameter int         MEM_DEPTH  = 16,
  parameter int         PTR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef I2C_MEM_WP_EN
  input  logic             wp,
`endif
  input  logic             scl,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_pulse,
  output logic [PTR_W-1:0] ptr
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge/condition detection.
  // The synchronisers reset to 1 (idle bus), so leaving reset creates no
  // false edges.
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_reg, sda_sync_reg;
  logic       scl_prev_reg, sda_prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], scl};
      sda_sync_reg <= {sda_sync_reg[0], sda_in};
      scl_prev_reg <= scl_sync_reg[1];
      sda_prev_reg <= sda_sync_reg[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s    = scl_sync_reg[1];
  assign sda_s    = sda_sync_reg[1];
  assign scl_rise =  scl_s & ~scl_prev_reg;
  assign scl_fall = ~scl_s &  scl_prev_reg;
  // SCL must be high on both samples, so an SDA change at the same time as
  // an SCL edge is never taken as START or STOP.
  assign start_det = scl_s & scl_prev_reg &  sda_prev_reg & ~sda_s;
  assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg &  sda_s;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [2:0]       bit_cnt_reg;
  logic [6:0]       shift_reg;     // 7 bits: the 8th bit is the live SDA sample
  logic             phase_reg;     // 0: before the ACK-slot fall, 1: after it
  logic             rw_reg;
  logic             ack_val_reg;
  logic             sda_oe_reg;
  logic             busy_reg;
  logic             wr_pulse_reg;
  logic [PTR_W-1:0] ptr_reg;

  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;
  logic [IDX_W-1:0] ptr_idx;
  logic [PTR_W-1:0] ptr_inc;
  logic             ptr_in_range;
  logic             write_ok;
  logic             mem_we;
  logic [8*MEM_DEPTH-1:0] mem_flat;

  assign rx_byte      = {shift_reg, sda_s};
  assign ptr_idx      = ptr_reg[IDX_W-1:0];
  assign ptr_inc      = (ptr_reg == PTR_W'(MEM_DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
  assign ptr_in_range = ({1'b0, rx_byte} < 9'(MEM_DEPTH));
  assign rd_byte      = mem_flat[{ptr_idx, 3'b000} +: 8];

`ifdef I2C_MEM_WP_EN
  assign write_ok = ~wp;
`else
  assign write_ok = 1'b1;
`endif

  // Commit happens on the 8th rising SCL of a data byte. It is blocked when
  // START or STOP arrives in the same clk, because those take priority.
  assign mem_we = (state_reg == WDATA) && scl_rise && (bit_cnt_reg == 3'd7) &&
                  !start_det && !stop_det && write_ok;

  // ---------------------------------------------------------------------------
  // Memory: one register per word, because every word must clear on reset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
      logic [7:0] word_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          word_reg <= 8'h00;
        else if (mem_we && (ptr_idx == IDX_W'(gi)))
          word_reg <= rx_byte;
      end
      assign mem_flat[gi*8 +: 8] = word_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      phase_reg    <= 1'b0;
      rw_reg       <= 1'b0;
      ack_val_reg  <= 1'b0;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      wr_pulse_reg <= 1'b0;
      ptr_reg      <= '0;
    end else begin
      wr_pulse_reg <= 1'b0;
      if (stop_det) begin
        // Any partial byte is dropped. The pointer is kept.
        state_reg   <= IDLE;
        sda_oe_reg  <= 1'b0;
        busy_reg    <= 1'b0;
        bit_cnt_reg <= '0;
        phase_reg   <= 1'b0;
      end else if (start_det) begin
        state_reg   <= ADDR;
        bit_cnt_reg <= '0;
        phase_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: ;

          ADDR: begin
            if (scl_fall) sda_oe_reg <= 1'b0;
            if (scl_rise) begin
              shift_reg   <= rx_byte[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_reg <= ADDR_ACK;
                  rw_reg    <= rx_byte[0];
                  busy_reg  <= 1'b1;
                  phase_reg <= 1'b0;
                end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                end
              end
            end
          end

          ADDR_ACK: if (scl_fall) begin
            if (!phase_reg) begin
              sda_oe_reg <= 1'b1;
              phase_reg  <= 1'b1;
            end else begin
              phase_reg   <= 1'b0;
              bit_cnt_reg <= '0;
              if (rw_reg) begin
                // Load the first read byte and drive its MSB on this fall.
                state_reg  <= RDATA;
                shift_reg  <= rd_byte[6:0];
                sda_oe_reg <= ~rd_byte[7];
              end else begin
                state_reg  <= PTR;
                sda_oe_reg <= 1'b0;
              end
            end
          end

          PTR: if (scl_rise) begin
            shift_reg   <= rx_byte[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              if (ptr_in_range) begin
                ptr_reg     <= PTR_W'(rx_byte);
                ack_val_reg <= 1'b1;
                phase_reg   <= 1'b0;
                state_reg   <= PTR_ACK;
              end else begin
                state_reg <= IDLE;      // SDA stays released, which is a NACK
                busy_reg  <= 1'b0;
              end
            end
          end

          PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!phase_reg) begin
              sda_oe_reg <= ack_val_reg;
              phase_reg  <= 1'b1;
            end else begin
              sda_oe_reg  <= 1'b0;
              phase_reg   <= 1'b0;
              bit_cnt_reg <= '0;
              state_reg   <= WDATA;
            end
          end

          WDATA: if (scl_rise) begin
            shift_reg   <= rx_byte[6:0];
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              wr_pulse_reg <= write_ok;
              ptr_reg      <= ptr_inc;
              ack_val_reg  <= write_ok;
              phase_reg    <= 1'b0;
              state_reg    <= WDATA_ACK;
            end
          end

          RDATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                ptr_reg   <= ptr_inc;
                phase_reg <= 1'b0;
                state_reg <= RDATA_ACK;
              end
            end else if (scl_fall) begin
              sda_oe_reg <= ~shift_reg[6];
              shift_reg  <= {shift_reg[5:0], 1'b0};
            end
          end

          RDATA_ACK: begin
            if (scl_fall) begin
              if (!phase_reg) begin
                sda_oe_reg <= 1'b0;     // let the master drive the ACK slot
                phase_reg  <= 1'b1;
              end else begin
                // The master ACKed, so serve the byte at the advanced pointer.
                phase_reg   <= 1'b0;
                bit_cnt_reg <= '0;
                shift_reg   <= rd_byte[6:0];
                sda_oe_reg  <= ~rd_byte[7];
                state_reg   <= RDATA;
              end
            end else if (scl_rise && sda_s) begin
              state_reg <= IDLE;        // master NACK ends the read
              busy_reg  <= 1'b0;
              phase_reg <= 1'b0;
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign busy     = busy_reg;
  assign wr_pulse = wr_pulse_reg;
  assign ptr      = ptr_reg;

endmodule

// File: doc/i2c_mem_slave_param.md
Name: i2c_mem_slave_param

Overview:
- Parametrised I2C memory slave, successor to the single-byte memory slave behind I2C_Wrapper.
- Adds a configurable 7-bit device address and memory depth, a register-pointer byte, multi-byte burst writes and reads with pointer auto-increment/wrap, and repeated-START support.
- Sits on the shared open-drain SDA/SCL bus. Oversamples SCL/SDA on the system clock.

Parameters:
- SLAVE_ADDR, 7'h1F, 7-bit device address matched against the first byte after START.
- MEM_DEPTH, 16, number of 8-bit memory words; legal range 2..256.
- PTR_W, 8, pointer register width; only the low clog2(MEM_DEPTH) bits index memory.

Ports:
- clk  input  1  system clock; must be >= 8x SCL frequency.
- rst  input  1  asynchronous active-low reset.
- scl  input  1  bus SCL level.
- sda_in  input  1  bus SDA level.
- sda_oe  output  1  1 = pull SDA low (open drain); the slave never drives high.
- busy  output  1  high from address match to STOP, NACK, or address mismatch.
- wr_pulse  output  1  one-cycle strobe when a data byte is committed to memory.
- ptr  output  PTR_W  current memory pointer.

Behaviour:
- Reset (rst=0, async): sda_oe=0, busy=0, wr_pulse=0, ptr=0, FSM=IDLE, all memory words=8'h00. Reset mid-transfer releases SDA immediately.
- Input sync: scl and sda_in each pass through a 2-flop synchroniser. Edges are detected on the synced values, giving a fixed 3-clk latency from pin to event.
- START: synced SDA 1->0 while SCL=1. STOP: synced SDA 0->1 while SCL=1. START/STOP take priority over bit events in every state.
- Sampling: bits are sampled on SCL rising edges. sda_oe changes only on SCL falling edges, plus async reset and STOP.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE -> ADDR on START; also from any state on repeated START.
- ADDR: shift 8 bits MSB first. Match on bits[7:1]==SLAVE_ADDR.
  - Match: go to ADDR_ACK and drive ACK (sda_oe=1) for the 9th bit.
  - Mismatch: sda_oe stays 0 and FSM -> IDLE, ignoring the bus until the next START.
- After ADDR_ACK:
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA. mem[ptr] is loaded into the shift register at the falling SCL that ends ACK, and bit7 is driven at once.
- PTR: receive 8 bits.
  - Value < MEM_DEPTH: ptr loaded, ACK, then WDATA.
  - Value >= MEM_DEPTH: NACK, ptr unchanged, FSM -> IDLE.
- WDATA: receive 8 bits. On the 8th rising SCL: mem[ptr] <= byte, wr_pulse=1 for one clk, ptr <= (ptr+1) mod MEM_DEPTH. Then ACK and loop to WDATA until STOP or START.
- RDATA: shift mem[ptr] MSB first. sda_oe = ~bit (drive low for 0). After the 8th bit, release SDA; ptr increments with wrap.
- RDATA_ACK: sample master ACK on rising SCL.
  - ACK (0): load the next byte, stay in RDATA.
  - NACK (1): release SDA, FSM -> IDLE.
- Wrap: ptr at MEM_DEPTH-1 increments to 0, for both write and read.
- STOP mid-byte: discard the partial byte, no write, release SDA, FSM -> IDLE, ptr retained.
- Repeated START after PTR_ACK: ptr retained, enabling the write-pointer-then-read idiom.
- busy: set on address-match ACK, cleared on entry to IDLE.

Optional Feature:
- Macro I2C_MEM_WP_EN.
- Defined: adds input port wp (1 bit). While wp=1, WDATA bytes are NACKed, memory is not written, wr_pulse stays 0, and ptr still increments. Pointer and address phases are unaffected.
- Undefined: no wp port; all writes are permitted.

Test Plan:
- Reset then write: START, 0x3E, ptr 0x03, data 0x0E, STOP -> three ACKs; mem[3]=0x0E; wr_pulse once; ptr=0x04.
- Random read: START, 0x3E, ptr 0x03, repeated START, 0x3F, read 1 byte with master NACK, STOP -> slave returns 0x0E; busy falls after NACK.
- Burst with wrap (MEM_DEPTH=16): write ptr 0x0E, data 0xA1, 0xA2, 0xA3 -> mem[14]=0xA1, mem[15]=0xA2, mem[0]=0xA3; ptr=0x01.
- Wrong address: START, 0xC7 -> SDA never pulled low; busy=0; the next valid START is accepted normally.
- Out-of-range pointer: ptr byte 0x10 with MEM_DEPTH=16 -> NACK on the pointer byte; ptr unchanged.
- Reset mid-read: assert rst during read bit 3 -> sda_oe=0 within the same clk; ptr=0; mem cleared to 0x00. With I2C_MEM_WP_EN and wp=1, a data byte is NACKed and mem is unchanged.
